// File: rtl/bpfvm_operand_stage_pkg.sv
// Shared encodings for the BPF VM operand stage: write destinations, write sources and FSM states.
package bpfvm_operand_stage_pkg;

    localparam int SCRATCH_AW_DEF = 4;
    localparam int DW_DEF         = 32;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_A    = 2'd1,
        DST_X    = 2'd2,
        DST_MEM  = 2'd3
    } dst_e;

    typedef enum logic [2:0] {
        SRC_IMM   = 3'd0,
        SRC_ALU   = 3'd1,
        SRC_MEM   = 3'd2,
        SRC_PKT   = 3'd3,
        SRC_OTHER = 3'd4,
        SRC_LEN   = 3'd5
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WAIT_PKT = 2'd2,
        ST_CLEAR    = 2'd3
    } state_e;

    function automatic logic is_reg_dst(input dst_e dst);
        return (dst == DST_A) || (dst == DST_X);
    endfunction

endpackage

// File: rtl/bpfvm_operand_stage_if.sv
// Request/operand bundle between bpfvm_ctrl/ALU (master) and the operand stage (slave).
interface bpfvm_operand_stage_if
    import bpfvm_operand_stage_pkg::*;
#(
    parameter int SCRATCH_AW = 4,
    parameter int DW         = 32
);
    logic                  req;
    dst_e                  req_dst;
    src_e                  req_src;
    logic [SCRATCH_AW-1:0] scratch_addr;
    logic [DW-1:0]         imm;
    logic [DW-1:0]         ALU_out;
    logic [DW-1:0]         pkt_len;
    logic [DW-1:0]         pkt_data;
    logic                  pkt_valid;
    logic                  B_sel;
    logic                  ready;
    logic                  done;
    logic [DW-1:0]         A_operand;
    logic [DW-1:0]         B_operand;
    logic [DW-1:0]         X_reg;

    modport master (
        output req, req_dst, req_src, scratch_addr, imm, ALU_out, pkt_len, pkt_data, pkt_valid, B_sel,
        input  ready, done, A_operand, B_operand, X_reg
    );

    modport slave (
        input  req, req_dst, req_src, scratch_addr, imm, ALU_out, pkt_len, pkt_data, pkt_valid, B_sel,
        output ready, done, A_operand, B_operand, X_reg
    );
endinterface

// File: rtl/bpfvm_operand_stage_scratch_mem.sv
// BPF scratch memory M[]: single port, synchronous write, one-cycle registered read.
module bpfvm_operand_stage_scratch_mem #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= {DW{1'b0}};
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/bpfvm_operand_stage.sv
// BPF VM operand stage: A/X registers, scratch M[], ALU operand muxing.
// Optional BPFVM_SCRATCH_CLEAR_EN: zero M[] word by word after every reset before going ready.
module bpfvm_operand_stage
    import bpfvm_operand_stage_pkg::*;
#(
    parameter int SCRATCH_AW = 4,
    parameter int DW         = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    bpfvm_operand_stage_if.slave   ops
);
`ifdef BPFVM_SCRATCH_CLEAR_EN
    localparam state_e RST_STATE = ST_CLEAR;
    logic [SCRATCH_AW-1:0] clr_q, clr_d;
`else
    localparam state_e RST_STATE = ST_IDLE;
`endif

    state_e                state_q, state_d;
    dst_e                  pend_q, pend_d;
    logic [DW-1:0]         a_q, a_d, x_q, x_d;
    logic                  done_q, done_d;
    logic                  wr_en_s;
    dst_e                  wr_dst_s;
    logic [DW-1:0]         wr_val_s;
    logic                  mem_we_s;
    logic [SCRATCH_AW-1:0] mem_addr_s;
    logic [DW-1:0]         mem_wdata_s, mem_rdata_s;

    bpfvm_operand_stage_scratch_mem #(.AW(SCRATCH_AW), .DW(DW)) u_scratch (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (mem_we_s),
        .addr_i (mem_addr_s),
        .wdata_i(mem_wdata_s),
        .rdata_o(mem_rdata_s)
    );

    // Next-state, register write-back and scratch port control.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        a_d         = a_q;
        x_d         = x_q;
        done_d      = 1'b0;
        wr_en_s     = 1'b0;
        wr_dst_s    = DST_NONE;
        wr_val_s    = {DW{1'b0}};
        mem_we_s    = 1'b0;
        mem_addr_s  = ops.scratch_addr;
        mem_wdata_s = a_q;
`ifdef BPFVM_SCRATCH_CLEAR_EN
        clr_d       = clr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ops.req) begin
                    done_d = 1'b1;
                    pend_d = ops.req_dst;
                    if (is_reg_dst(ops.req_dst)) begin
                        wr_dst_s = ops.req_dst;
                        case (ops.req_src)
                            SRC_IMM:   begin wr_en_s = 1'b1; wr_val_s = ops.imm;     end
                            SRC_ALU:   begin wr_en_s = 1'b1; wr_val_s = ops.ALU_out; end
                            SRC_LEN:   begin wr_en_s = 1'b1; wr_val_s = ops.pkt_len; end
                            SRC_OTHER: begin
                                wr_en_s  = 1'b1;
                                wr_val_s = (ops.req_dst == DST_A) ? x_q : a_q;
                            end
                            SRC_MEM:   begin done_d = 1'b0; state_d = ST_WAIT_MEM; end
                            SRC_PKT:   begin done_d = 1'b0; state_d = ST_WAIT_PKT; end
                            default:   wr_en_s = 1'b0;
                        endcase
                    end else if (ops.req_dst == DST_MEM) begin
                        // ST stores A (src OTHER), STX stores X (src ALU encoding).
                        case (ops.req_src)
                            SRC_OTHER: begin mem_we_s = 1'b1; mem_wdata_s = a_q; end
                            SRC_ALU:   begin mem_we_s = 1'b1; mem_wdata_s = x_q; end
                            default:   mem_we_s = 1'b0;
                        endcase
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_WAIT_MEM: begin
                wr_en_s  = 1'b1;
                wr_dst_s = pend_q;
                wr_val_s = mem_rdata_s;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_WAIT_PKT: begin
                if (ops.pkt_valid) begin
                    wr_en_s  = 1'b1;
                    wr_dst_s = pend_q;
                    wr_val_s = ops.pkt_data;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_WAIT_PKT;
                end
            end
`ifdef BPFVM_SCRATCH_CLEAR_EN
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = clr_q;
                mem_wdata_s = {DW{1'b0}};
                clr_d       = clr_q + {{(SCRATCH_AW-1){1'b0}}, 1'b1};
                if (clr_q == {SCRATCH_AW{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (wr_en_s && (wr_dst_s == DST_A)) begin
            a_d = wr_val_s;
        end else if (wr_en_s && (wr_dst_s == DST_X)) begin
            x_d = wr_val_s;
        end else begin
            a_d = a_q;
        end
    end

    // State and architectural register update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
            pend_q  <= DST_NONE;
            a_q     <= {DW{1'b0}};
            x_q     <= {DW{1'b0}};
            done_q  <= 1'b0;
`ifdef BPFVM_SCRATCH_CLEAR_EN
            clr_q   <= {SCRATCH_AW{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
            x_q     <= x_d;
            done_q  <= done_d;
`ifdef BPFVM_SCRATCH_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end

    assign ops.ready     = (state_q == ST_IDLE);
    assign ops.done      = done_q;
    assign ops.A_operand = a_q;
    assign ops.B_operand = ops.B_sel ? ops.imm : x_q;
    assign ops.X_reg     = x_q;
endmodule

// File: tb/tb_bpfvm_operand_stage.sv
// Directed, table-driven bench for bpfvm_operand_stage.
module tb_bpfvm_operand_stage;
    import bpfvm_operand_stage_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bpfvm_operand_stage_if #(.SCRATCH_AW(4), .DW(32)) ops ();

    bpfvm_operand_stage #(.SCRATCH_AW(4), .DW(32)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .ops  (ops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        dst_e        dst;
        src_e        src;
        logic [3:0]  addr;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] len;
        logic        bsel;
        logic [31:0] exp_a;
        logic [31:0] exp_x;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ops.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, ops.ready}, 32'd1);
    endtask

    task automatic idle_inputs();
        ops.req          = 1'b0;
        ops.req_dst      = DST_NONE;
        ops.req_src      = SRC_IMM;
        ops.scratch_addr = 4'd0;
        ops.imm          = 32'd0;
        ops.ALU_out      = 32'd0;
        ops.pkt_len      = 32'd0;
        ops.pkt_data     = 32'd0;
        ops.pkt_valid    = 1'b0;
        ops.B_sel        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowcnt;
        errors = 0;
        checks = 0;
        vecs[0]  = '{DST_A,    SRC_IMM,   4'd0, 32'h0000_0800, 32'h0,         32'h0,     1'b1, 32'h0000_0800, 32'h0000_0000};
        vecs[1]  = '{DST_X,    SRC_IMM,   4'd0, 32'h0000_1234, 32'h0,         32'h0,     1'b0, 32'h0000_0800, 32'h0000_1234};
        vecs[2]  = '{DST_A,    SRC_ALU,   4'd0, 32'h0,         32'hDEAD_BEEF, 32'h0,     1'b0, 32'hDEAD_BEEF, 32'h0000_1234};
        vecs[3]  = '{DST_X,    SRC_LEN,   4'd0, 32'h0,         32'h0,         32'h5EA,   1'b0, 32'hDEAD_BEEF, 32'h0000_05EA};
        vecs[4]  = '{DST_A,    SRC_OTHER, 4'd0, 32'h0,         32'h0,         32'h0,     1'b0, 32'h0000_05EA, 32'h0000_05EA};
        vecs[5]  = '{DST_A,    SRC_IMM,   4'd0, 32'h0F0F_0F0F, 32'h0,         32'h0,     1'b1, 32'h0F0F_0F0F, 32'h0000_05EA};
        vecs[6]  = '{DST_X,    SRC_OTHER, 4'd0, 32'h0,         32'h0,         32'h0,     1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
        vecs[7]  = '{DST_NONE, SRC_IMM,   4'd0, 32'h0000_0111, 32'h0,         32'h0,     1'b1, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
        vecs[8]  = '{DST_MEM,  SRC_LEN,   4'd3, 32'h0,         32'h0,         32'h77,    1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
        vecs[9]  = '{DST_A,    SRC_IMM,   4'd0, 32'hCAFE_0001, 32'h0,         32'h0,     1'b0, 32'hCAFE_0001, 32'h0F0F_0F0F};
        vecs[10] = '{DST_MEM,  SRC_OTHER, 4'd5, 32'h0,         32'h0,         32'h0,     1'b0, 32'hCAFE_0001, 32'h0F0F_0F0F};
        vecs[11] = '{DST_X,    SRC_IMM,   4'd0, 32'h0BAD_F00D, 32'h0,         32'h0,     1'b0, 32'hCAFE_0001, 32'h0BAD_F00D};
        vecs[12] = '{DST_MEM,  SRC_ALU,   4'd6, 32'h0,         32'h1234_5678, 32'h0,     1'b0, 32'hCAFE_0001, 32'h0BAD_F00D};
        vecs[13] = '{DST_X,    SRC_IMM,   4'd0, 32'h0,         32'h0,         32'h0,     1'b0, 32'hCAFE_0001, 32'h0000_0000};
        vecs[14] = '{DST_A,    SRC_IMM,   4'd0, 32'h0,         32'h0,         32'h0,     1'b0, 32'h0000_0000, 32'h0000_0000};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ready("reset_ready");
        check("reset_A", ops.A_operand, 32'd0);
        check("reset_X", ops.X_reg, 32'd0);
        check("reset_done", {31'd0, ops.done}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            ops.req          = 1'b1;
            ops.req_dst      = vecs[i].dst;
            ops.req_src      = vecs[i].src;
            ops.scratch_addr = vecs[i].addr;
            ops.imm          = vecs[i].imm;
            ops.ALU_out      = vecs[i].alu;
            ops.pkt_len      = vecs[i].len;
            ops.B_sel        = vecs[i].bsel;
            @(negedge clk);
            ops.req = 1'b0;
            check($sformatf("v%0d_A", i), ops.A_operand, vecs[i].exp_a);
            check($sformatf("v%0d_X", i), ops.X_reg, vecs[i].exp_x);
            check($sformatf("v%0d_B", i), ops.B_operand, vecs[i].bsel ? vecs[i].imm : vecs[i].exp_x);
            check($sformatf("v%0d_done", i), {31'd0, ops.done}, 32'd1);
            check($sformatf("v%0d_ready", i), {31'd0, ops.ready}, 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_done_low", i), {31'd0, ops.done}, 32'd0);
        end

        // Load M[5] into X; a request during WAIT_MEM must be ignored.
        ops.req = 1'b1; ops.req_dst = DST_X; ops.req_src = SRC_MEM; ops.scratch_addr = 4'd5;
        @(negedge clk);
        check("ldm_busy_ready", {31'd0, ops.ready}, 32'd0);
        check("ldm_busy_done", {31'd0, ops.done}, 32'd0);
        ops.req_src = SRC_IMM; ops.imm = 32'h0000_0099;
        @(negedge clk);
        ops.req = 1'b0;
        check("ldm_X", ops.X_reg, 32'hCAFE_0001);
        check("ldm_done", {31'd0, ops.done}, 32'd1);
        check("ldm_ready", {31'd0, ops.ready}, 32'd1);
        @(negedge clk);
        check("ignored_req_X", ops.X_reg, 32'hCAFE_0001);
        check("ldm_done_low", {31'd0, ops.done}, 32'd0);

        // STX must have stored X, not ALU_out.
        ops.req = 1'b1; ops.req_dst = DST_A; ops.req_src = SRC_MEM; ops.scratch_addr = 4'd6;
        @(negedge clk);
        ops.req = 1'b0;
        @(negedge clk);
        check("ldm6_A", ops.A_operand, 32'h0BAD_F00D);
        check("ldm6_done", {31'd0, ops.done}, 32'd1);

        // pkt_valid in IDLE is ignored.
        ops.pkt_valid = 1'b1; ops.pkt_data = 32'h0000_0BAD;
        @(negedge clk);
        ops.pkt_valid = 1'b0;
        @(negedge clk);
        check("pkt_idle_A", ops.A_operand, 32'h0BAD_F00D);
        check("pkt_idle_done", {31'd0, ops.done}, 32'd0);

        // Packet load with pkt_valid held low for 7 WAIT_PKT edges.
        ops.req = 1'b1; ops.req_dst = DST_A; ops.req_src = SRC_PKT; ops.pkt_data = 32'h4500_0054;
        @(negedge clk);
        ops.req = 1'b0;
        lowcnt = 0;
        while (!ops.ready && lowcnt < 50) begin
            lowcnt++;
            if (lowcnt == 8) ops.pkt_valid = 1'b1;
            @(negedge clk);
        end
        ops.pkt_valid = 1'b0;
        check("pkt_ready_low_cycles", lowcnt, 32'd8);
        check("pkt_A", ops.A_operand, 32'h4500_0054);
        check("pkt_done", {31'd0, ops.done}, 32'd1);

        // Reset while in WAIT_PKT with pkt_valid high aborts the load.
        @(negedge clk);
        ops.req = 1'b1; ops.req_dst = DST_A; ops.req_src = SRC_PKT; ops.pkt_data = 32'h1234_ABCD;
        @(negedge clk);
        ops.req = 1'b0;
        check("abort_busy_ready", {31'd0, ops.ready}, 32'd0);
        rst = 1'b1; ops.pkt_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; ops.pkt_valid = 1'b0;
        check("abort_A", ops.A_operand, 32'd0);
        check("abort_done", {31'd0, ops.done}, 32'd0);
        @(negedge clk);
        check("abort_done_later", {31'd0, ops.done}, 32'd0);
        wait_ready("abort_ready");
        check("abort_A_final", ops.A_operand, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
